// File: rtl/vx_smem_bank_responder.sv
// Shared-memory bank responder. It captures one request batch, services the
// valid lanes one per cycle in ascending lane order against a local word
// array, then returns a single response carrying the tmask, per-lane data and
// the batch tag.
module vx_smem_bank_responder #(
  parameter int LANES         = 4,
  parameter int DATA_SIZE     = 4,
  parameter int ADDR_WIDTH    = 30,
  parameter int TAG_WIDTH     = 8,
  parameter int DEPTH         = 256,
  parameter int WRITE_RSP     = 0,
  parameter int INST_MOD_BITS = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [LANES-1:0]                req_valid_in,
  input  logic [LANES-1:0]                req_rw_in,
  input  logic [LANES*INST_MOD_BITS-1:0]  req_op_mod_in,
  input  logic [LANES-1:0]                req_is_amo_in,
  input  logic [LANES*DATA_SIZE-1:0]      req_byteen_in,
  input  logic [LANES*ADDR_WIDTH-1:0]     req_addr_in,
  input  logic [LANES*8*DATA_SIZE-1:0]    req_data_in,
  input  logic [LANES*TAG_WIDTH-1:0]      req_tag_in,
  output logic [LANES-1:0]                req_ready_in,
  output logic                            rsp_valid_out,
  output logic [LANES-1:0]                rsp_tmask_out,
  output logic [LANES*8*DATA_SIZE-1:0]    rsp_data_out,
  output logic [TAG_WIDTH-1:0]            rsp_tag_out,
  input  logic                            rsp_ready_out
);

  localparam int DATA_WIDTH = 8 * DATA_SIZE;
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, PROC, RSP} state_e;

  // Atomic update: old value combined with the lane operand.
  function automatic logic [DATA_WIDTH-1:0] amo_f(input logic [INST_MOD_BITS-1:0] op,
                                                  input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] opnd);
    case (op)
      1:       amo_f = old + opnd;
      2:       amo_f = old & opnd;
      3:       amo_f = old | opnd;
      4:       amo_f = old ^ opnd;
      default: amo_f = opnd;
    endcase
  endfunction

  // Byte-enabled merge of write data into the stored word.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(input logic [DATA_WIDTH-1:0] old,
                                                       input logic [DATA_WIDTH-1:0] wdat,
                                                       input logic [DATA_SIZE-1:0]  be);
    byte_merge = old;
    for (int b = 0; b < DATA_SIZE; b++)
      if (be[b]) byte_merge[b*8 +: 8] = wdat[b*8 +: 8];
  endfunction

  state_e                           state_q;
  logic [LANES-1:0]                 ready_q;
  logic                             rsp_valid_q;
  logic [LANES-1:0]                 rsp_tmask_q;
  logic [LANES*DATA_WIDTH-1:0]      rsp_data_q;
  logic [TAG_WIDTH-1:0]             rsp_tag_q;
  logic [LANES-1:0]                 pend_q, pend_d;
  logic [LANES-1:0]                 valid_q;

  logic [LANES-1:0]                 rw_q;
  logic [LANES-1:0]                 amo_q;
  logic [INST_MOD_BITS-1:0]         op_q   [LANES];
  logic [DATA_SIZE-1:0]             be_q   [LANES];
  logic [IDX_W-1:0]                 idx_q  [LANES];
  logic [DATA_WIDTH-1:0]            wdat_q [LANES];

  logic [DATA_WIDTH-1:0]            mem_q  [DEPTH];

  logic                             cap;
  logic [TAG_WIDTH-1:0]             cap_tag;
  logic                             tags_match;
  logic [LANE_W-1:0]                sel;
  logic                             found;
  logic [DATA_WIDTH-1:0]            svc_old;
  logic [DATA_WIDTH-1:0]            svc_wval;
  logic [DATA_WIDTH-1:0]            svc_ret;
  logic                             svc_we;
  logic [LANES-1:0]                 tmask_d;
  logic                             unused_addr_hi;

  // Only the index bits of each address reach the array; upper bits alias.
  assign unused_addr_hi = ^req_addr_in;

  assign cap     = (state_q == IDLE) && ready_q[0] && (|req_valid_in);
  assign tmask_d = (WRITE_RSP != 0) ? valid_q : (valid_q & (~rw_q | amo_q));
  assign svc_old = mem_q[idx_q[sel]];
  assign pend_d  = pend_q & ~(LANES'(1) << sel);

  // Batch tag comes from the lowest valid lane; flag any lane that disagrees.
  always_comb begin
    cap_tag    = '0;
    tags_match = 1'b1;
    for (int l = LANES-1; l >= 0; l--)
      if (req_valid_in[l]) cap_tag = req_tag_in[l*TAG_WIDTH +: TAG_WIDTH];
    for (int l = 0; l < LANES; l++)
      if (req_valid_in[l] && (req_tag_in[l*TAG_WIDTH +: TAG_WIDTH] != cap_tag)) tags_match = 1'b0;
  end

  // Pick the lowest pending lane to service this cycle.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int l = LANES-1; l >= 0; l--)
      if (pend_q[l]) begin
        sel   = LANE_W'(l);
        found = 1'b1;
      end
  end

  // Per-lane access: read returns the word, write merges bytes, AMO returns old and updates.
  always_comb begin
    svc_we   = 1'b0;
    svc_wval = svc_old;
    svc_ret  = '0;
    if (state_q == PROC && found) begin
      if (amo_q[sel]) begin
        svc_we   = 1'b1;
        svc_wval = amo_f(op_q[sel], svc_old, wdat_q[sel]);
        svc_ret  = svc_old;
      end else if (rw_q[sel]) begin
        svc_we   = 1'b1;
        svc_wval = byte_merge(svc_old, wdat_q[sel], be_q[sel]);
      end else begin
        svc_ret  = svc_old;
      end
    end
  end

  // Word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (svc_we) mem_q[idx_q[sel]] <= svc_wval;
  end

  // Latch the per-lane request fields when a batch is accepted.
  always_ff @(posedge clk) begin
    if (cap) begin
      rw_q  <= req_rw_in;
      amo_q <= req_is_amo_in;
      for (int l = 0; l < LANES; l++) begin
        op_q[l]   <= req_op_mod_in[l*INST_MOD_BITS +: INST_MOD_BITS];
        be_q[l]   <= req_byteen_in[l*DATA_SIZE +: DATA_SIZE];
        idx_q[l]  <= req_addr_in[l*ADDR_WIDTH +: IDX_W];
        wdat_q[l] <= req_data_in[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Control FSM: accept, serialise lanes, then hold the response until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ready_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tmask_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      pend_q      <= '0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cap) begin
            state_q     <= PROC;
            ready_q     <= '0;
            pend_q      <= req_valid_in;
            valid_q     <= req_valid_in;
            rsp_tag_q   <= cap_tag;
            rsp_data_q  <= '0;
            rsp_tmask_q <= '0;
          end else begin
            ready_q     <= '1;
          end
        end
        PROC: begin
          if (found) begin
            pend_q <= pend_d;
            rsp_data_q[sel*DATA_WIDTH +: DATA_WIDTH] <= svc_ret;
          end else begin
            rsp_tmask_q <= tmask_d;
            if (|tmask_d) begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q     <= IDLE;
              ready_q     <= '1;
            end
          end
        end
        RSP: begin
          if (rsp_ready_out) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            ready_q     <= '1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= '0;
        end
      endcase
    end
  end

  // All valid lanes of one batch are expected to carry the same tag.
  assert property (@(posedge clk) disable iff (!reset) cap |-> tags_match);

  assign req_ready_in  = ready_q;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_tmask_out = rsp_tmask_q;
  assign rsp_data_out  = rsp_data_q;
  assign rsp_tag_out   = rsp_tag_q;

endmodule

// File: tb/tb_vx_smem_bank_responder.sv
// Directed bench for vx_smem_bank_responder (LANES=4, 32-bit words, DEPTH=256, WRITE_RSP=0).
module tb_vx_smem_bank_responder;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    req_valid_in = '0;
  logic [3:0]    req_rw_in = '0;
  logic [11:0]   req_op_mod_in = '0;
  logic [3:0]    req_is_amo_in = '0;
  logic [15:0]   req_byteen_in = '0;
  logic [119:0]  req_addr_in = '0;
  logic [127:0]  req_data_in = '0;
  logic [31:0]   req_tag_in = '0;
  logic [3:0]    req_ready_in;
  logic          rsp_valid_out;
  logic [3:0]    rsp_tmask_out;
  logic [127:0]  rsp_data_out;
  logic [7:0]    rsp_tag_out;
  logic          rsp_ready_out = 1'b0;

  vx_smem_bank_responder dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_in  (req_valid_in),
    .req_rw_in     (req_rw_in),
    .req_op_mod_in (req_op_mod_in),
    .req_is_amo_in (req_is_amo_in),
    .req_byteen_in (req_byteen_in),
    .req_addr_in   (req_addr_in),
    .req_data_in   (req_data_in),
    .req_tag_in    (req_tag_in),
    .req_ready_in  (req_ready_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_tmask_out (rsp_tmask_out),
    .rsp_data_out  (rsp_data_out),
    .rsp_tag_out   (rsp_tag_out),
    .rsp_ready_out (rsp_ready_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0]       rw;
    logic [3:0]       amo;
    logic [11:0]      op;
    logic [15:0]      be;
    logic [3:0][9:0]  addr;
    logic [3:0][31:0] data;
    logic [7:0]       tag;
    logic [3:0]       etm;
    logic [3:0][31:0] edata;
    int               elat;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vt[18];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid_in  = v.valid;
    req_rw_in     = v.rw;
    req_is_amo_in = v.amo;
    req_op_mod_in = v.op;
    req_byteen_in = v.be;
    req_data_in   = v.data;
    req_tag_in    = {4{v.tag}};
    for (int l = 0; l < 4; l++) req_addr_in[l*30 +: 30] = 30'(v.addr[l]);
  endtask

  // Send one batch, measure latency, check the response (held for 'hold' cycles first).
  task automatic run_vec(input vec_t v, input string nm, input int hold);
    int n;
    logic seen;
    logic [127:0] snap;
    n = 0;
    while (!req_ready_in[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({nm, " ready_timeout"}, 128'(n), 128'(0));
    drive(v);
    @(negedge clk);
    req_valid_in = '0;
    n = 0;
    seen = 1'b0;
    if (v.etm != 4'h0) begin
      while (!rsp_valid_out && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk({nm, " latency"}, 128'(n), 128'(v.elat));
      chk({nm, " tmask"}, 128'(rsp_tmask_out), 128'(v.etm));
      chk({nm, " data"}, rsp_data_out, v.edata);
      chk({nm, " tag"}, 128'(rsp_tag_out), 128'(v.tag));
      snap = rsp_data_out;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({nm, " hold_stable"}, {rsp_data_out[119:0], rsp_valid_out, rsp_tmask_out, req_ready_in},
            {snap[119:0], 1'b1, v.etm, 4'h0});
      end
      rsp_ready_out = 1'b1;
      @(negedge clk);
      rsp_ready_out = 1'b0;
      chk({nm, " rsp_drop"}, 128'(rsp_valid_out), 128'(0));
    end else begin
      while (!req_ready_in[0] && n < 30) begin
        @(negedge clk);
        n++;
        if (rsp_valid_out) seen = 1'b1;
      end
      chk({nm, " ready_back"}, 128'(n), 128'(v.elat));
      chk({nm, " no_rsp"}, 128'(seen), 128'(0));
    end
  endtask

  initial begin
    vec_t h;
    logic seen;

    //          valid rw    amo   op       be        addr {l3,l2,l1,l0}                      data {l3,l2,l1,l0}                                         tag    etm   edata {l3,l2,l1,l0}                                         lat
    vt[0]  = '{4'h1, 4'h1, 4'h0, 12'h000, 16'h000F, {10'h0, 10'h0, 10'h0, 10'h5},     {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},                        8'h01, 4'h0, '0,                                                       2};
    vt[1]  = '{4'h1, 4'h0, 4'h0, 12'h000, 16'h0000, {10'h0, 10'h0, 10'h0, 10'h5},     '0,                                                         8'h02, 4'h1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},                     2};
    vt[2]  = '{4'hF, 4'hF, 4'h0, 12'h000, 16'hFFFF, {10'h4, 10'h3, 10'h2, 10'h1},     {32'd40, 32'd30, 32'd20, 32'd10},                           8'h03, 4'h0, '0,                                                       5};
    vt[3]  = '{4'hF, 4'h0, 4'h0, 12'h000, 16'h0000, {10'h4, 10'h3, 10'h2, 10'h1},     '0,                                                         8'h3C, 4'hF, {32'd40, 32'd30, 32'd20, 32'd10},                        5};
    vt[4]  = '{4'h1, 4'h1, 4'h0, 12'h000, 16'h000F, {10'h0, 10'h0, 10'h0, 10'h7},     {32'h0, 32'h0, 32'h0, 32'h11223344},                        8'h04, 4'h0, '0,                                                       2};
    vt[5]  = '{4'h1, 4'h1, 4'h0, 12'h000, 16'h0005, {10'h0, 10'h0, 10'h0, 10'h7},     {32'h0, 32'h0, 32'h0, 32'hAABBCCDD},                        8'h05, 4'h0, '0,                                                       2};
    vt[6]  = '{4'h1, 4'h0, 4'h0, 12'h000, 16'h0000, {10'h0, 10'h0, 10'h0, 10'h7},     '0,                                                         8'h06, 4'h1, {32'h0, 32'h0, 32'h0, 32'h11BB33DD},                     2};
    vt[7]  = '{4'h1, 4'h1, 4'h0, 12'h000, 16'h000F, {10'h0, 10'h0, 10'h0, 10'h9},     {32'h0, 32'h0, 32'h0, 32'd5},                               8'h07, 4'h0, '0,                                                       2};
    vt[8]  = '{4'h3, 4'h0, 4'h3, 12'h009, 16'h0000, {10'h0, 10'h0, 10'h9, 10'h9},     {32'h0, 32'h0, 32'd2, 32'd1},                               8'h08, 4'h3, {32'h0, 32'h0, 32'd6, 32'd5},                            3};
    vt[9]  = '{4'h1, 4'h0, 4'h0, 12'h000, 16'h0000, {10'h0, 10'h0, 10'h0, 10'h9},     '0,                                                         8'h09, 4'h1, {32'h0, 32'h0, 32'h0, 32'd8},                            2};
    vt[10] = '{4'hB, 4'h1, 4'h8, 12'h800, 16'h000F, {10'h10, 10'h0, 10'h10, 10'h10},  {32'hFFFF0000, 32'h0, 32'h0, 32'h12345678},                 8'h0A, 4'hA, {32'h12345678, 32'h0, 32'h12345678, 32'h0},              4};
    vt[11] = '{4'h4, 4'h0, 4'h0, 12'h000, 16'h0000, {10'h0, 10'h110, 10'h0, 10'h0},   '0,                                                         8'h0B, 4'h4, {32'h0, 32'hEDCB5678, 32'h0, 32'h0},                     2};
    vt[12] = '{4'h1, 4'h1, 4'h0, 12'h000, 16'h000F, {10'h0, 10'h0, 10'h0, 10'h20},    {32'h0, 32'h0, 32'h0, 32'hF0F0F0F0},                        8'h0C, 4'h0, '0,                                                       2};
    vt[13] = '{4'hF, 4'h0, 4'hF, 12'hC1A, 16'h0000, {10'h20, 10'h20, 10'h20, 10'h20}, {32'hCAFEBABE, 32'h12345678, 32'h0000000F, 32'hFF00FF00},  8'h0D, 4'hF, {32'h12345678, 32'hF000F00F, 32'hF000F000, 32'hF0F0F0F0}, 5};
    vt[14] = '{4'h1, 4'h0, 4'h0, 12'h000, 16'h0000, {10'h0, 10'h0, 10'h0, 10'h20},    '0,                                                         8'h0E, 4'h1, {32'h0, 32'h0, 32'h0, 32'hCAFEBABE},                     2};
    vt[15] = '{4'h1, 4'h1, 4'h0, 12'h000, 16'h000F, {10'h0, 10'h0, 10'h0, 10'h30},    {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF},                        8'h0F, 4'h0, '0,                                                       2};
    vt[16] = '{4'h1, 4'h0, 4'h1, 12'h001, 16'h0000, {10'h0, 10'h0, 10'h0, 10'h30},    {32'h0, 32'h0, 32'h0, 32'd2},                               8'h10, 4'h1, {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF},                     2};
    vt[17] = '{4'h3, 4'h1, 4'h0, 12'h000, 16'h0000, {10'h0, 10'h0, 10'h30, 10'h30},   '0,                                                         8'h11, 4'h2, {32'h0, 32'h0, 32'd1, 32'h0},                            3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rsp_valid_out, rsp_tmask_out, rsp_tag_out, req_ready_in}, 128'h0);
    chk("reset_data", rsp_data_out, 128'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", 128'(req_ready_in), 128'hF);

    for (int i = 0; i < 18; i++) run_vec(vt[i], $sformatf("vec%0d", i), 0);

    // Response held under backpressure for 10 cycles
    h = vt[1];
    h.tag = 8'h55;
    run_vec(h, "hold", 10);

    // Preload 0x40..0x43, then reset in the middle of an overwrite batch
    h = '{4'hF, 4'hF, 4'h0, 12'h000, 16'hFFFF, {10'h43, 10'h42, 10'h41, 10'h40},
          {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h20, 4'h0, '0, 5};
    run_vec(h, "preload", 0);
    h.data = {32'd4, 32'd3, 32'd2, 32'd1};
    h.tag  = 8'h21;
    drive(h);
    @(negedge clk);
    req_valid_in = '0;
    chk("midrst_accepted", 128'(req_ready_in), 128'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_outputs", {rsp_valid_out, rsp_tmask_out, req_ready_in}, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid_out) seen = 1'b1;
    end
    chk("midrst_no_rsp", 128'(seen), 128'(0));
    h = '{4'hF, 4'h0, 4'h0, 12'h000, 16'h0000, {10'h43, 10'h42, 10'h41, 10'h40},
          '0, 8'h22, 4'hF, {32'hA3, 32'hA2, 32'd2, 32'd1}, 5};
    run_vec(h, "after_midrst", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
